rr_mux_n: RTL and testbench
===========================

# rr_mux_n

Parametrised N-channel, W-bit arbitrated multiplexer with a registered output stage and a valid/ready handshake on every port. It succeeds the combinational 2:1/4:1 mux tree. The select is generated internally by a round-robin arbiter, or forced by an external select in lock mode. It sits wherever several producers share one downstream consumer, for example register-file read ports or memory request merging.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2, need not be a power of two)
- SEL_W, $clog2(CHANNELS), derived width of select/index fields; not overridden

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit set per cycle
- lock  input  1  0 = round-robin mode; 1 = forced mode, only lock_sel eligible
- lock_sel  input  SEL_W  forced channel index
- out_data  output  WIDTH  registered data
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat
- in_last  input  CHANNELS  end-of-packet flag per channel (present only with RR_MUX_HOLD_EN)

## Operation
- One-entry output register. load_en = !out_valid | out_ready.
- Eligible set:
  - Round-robin mode: all channels with in_valid.
  - Forced mode: channel lock_sel only, if its in_valid is set and lock_sel < CHANNELS. Otherwise the set is empty.
- Round-robin grant: the first eligible channel at or after pointer ptr, scanning upward and wrapping from CHANNELS-1 to 0.
- in_ready[g] = load_en & grant valid. All other bits of in_ready are 0. in_ready does not depend on in_valid of other channels beyond the grant scan.
- Transfer on channel g (in_valid[g] & in_ready[g]):
  - out_data ← in_data[g], out_sel ← g, out_valid ← 1.
  - In round-robin mode, ptr ← (g+1) mod CHANNELS.
- Forced-mode transfers leave ptr unchanged.
- If out_ready is set and no transfer occurs, out_valid ← 0. out_data and out_sel hold their last values.
- Drain and load in the same cycle are legal, giving one beat per cycle sustained throughput.
- out_data and out_sel are stable while out_valid & !out_ready.
- A change of lock or lock_sel takes effect on the next grant evaluation and never disturbs the beat already in the output register.

## Timing
- Reset values: out_valid 0, out_data 0, out_sel 0, ptr 0, in_ready all 0 while rst_n low.
- Hold state is IDLE at reset (with RR_MUX_HOLD_EN).
- Latency: input accepted at edge N appears on out_* after edge N, valid in cycle N+1.
- in_ready is combinational from in_valid, lock, lock_sel, out_valid, out_ready and state. There is no combinational path from in_data to any output.
- Reset asserted mid-transfer clears out_valid immediately (asynchronously). A beat in the output register is discarded.
- First edge after deassertion behaves as from empty.
- Pointer wrap: a grant to CHANNELS-1 sets ptr to 0.

## Configuration
Macro: RR_MUX_HOLD_EN.
- Defined:
  - The in_last port exists.
  - Two-state hold FSM: IDLE and HELD(h).
  - IDLE → HELD(g) on a transfer from g with in_last[g] = 0. Arbitration continues normally in IDLE.
  - In HELD(h), only channel h is eligible, regardless of lock or ptr, until a transfer from h with in_last[h] = 1. That transfer returns the FSM to IDLE and sets ptr ← (h+1) mod CHANNELS.
  - Packets of one beat (last = 1 in IDLE) never enter HELD.
- Undefined:
  - No in_last port and no FSM.
  - Each beat is arbitrated independently.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 4'b1111 → in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0.
- Fairness: CHANNELS = 4, all valid, out_ready = 1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3, one beat per cycle; data matches the source channel.
- Backpressure: out_ready = 0 with a beat held → out_data and out_sel stable and in_ready = 0 for 5 cycles. Raising out_ready gives a drain and a new load in the same cycle.
- Forced mode: lock = 1, lock_sel = 2, all valid → only channel 2 is granted and ptr is unchanged. lock_sel = 3 with in_valid[3] = 0 → no grant, out_valid falls after drain.
- Non-power-of-two: CHANNELS = 3, channels 0 and 2 valid → sel 0,2,0,2. ptr wraps from 2 to 0.
- Hold (RR_MUX_HOLD_EN): channel 1 sends a 3-beat packet (last on beat 3) while channel 0 is valid → out_sel 1,1,1 then 0. Reset asserted at beat 2 returns to IDLE with out_valid = 0.

Source files
------------

// File: rtl/rr_mux_n.sv
// rr_mux_n: CHANNELS-to-1 arbitrated mux with a one-entry registered output and valid/ready on every port.
// Defining RR_MUX_HOLD_EN adds in_last and an IDLE/HELD FSM that keeps a packet's channel granted to its last beat.
module rr_mux_n #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
`ifdef RR_MUX_HOLD_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    input  logic                      lock,
    input  logic [SEL_W-1:0]          lock_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    ptr_next;
    logic [CHANNELS-1:0] eligible;
    logic [SEL_W:0]      scan_idx;
    logic                grant_valid;
    logic [SEL_W-1:0]    grant;
    logic [WIDTH-1:0]    grant_data;
    logic                load_en;
    logic                xfer;

`ifdef RR_MUX_HOLD_EN
    typedef enum logic {IDLE, HELD} hold_state_t;
    hold_state_t      state;
    hold_state_t      state_next;
    logic [SEL_W-1:0] held_ch;
    logic [SEL_W-1:0] held_ch_next;
`endif

    function automatic logic [SEL_W-1:0] next_index(input logic [SEL_W-1:0] idx);
        return (idx == SEL_W'(CHANNELS - 1)) ? '0 : idx + 1'b1;
    endfunction

    // An out-of-range lock_sel never matches any channel, so forced mode then grants nothing.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            eligible[i] = in_valid[i] && (!lock || (lock_sel == SEL_W'(i)));
`ifdef RR_MUX_HOLD_EN
            if (state == HELD) eligible[i] = in_valid[i] && (held_ch == SEL_W'(i));
`endif
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        scan_idx    = '0;
        for (int off = 0; off < CHANNELS; off++) begin
            scan_idx = {1'b0, ptr} + (SEL_W+1)'(off);
            if (scan_idx >= (SEL_W+1)'(CHANNELS)) scan_idx = scan_idx - (SEL_W+1)'(CHANNELS);
            if (!grant_valid && eligible[scan_idx[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant       = scan_idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign load_en = !out_valid || out_ready;
    assign xfer    = load_en && grant_valid;

    // in_ready is gated by rst_n so nothing looks accepted while the block is held in reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst_n && xfer && (grant == SEL_W'(i));
        end
    end

    always_comb begin
        ptr_next = ptr;
`ifdef RR_MUX_HOLD_EN
        if (xfer && state == HELD) begin
            if (in_last[grant]) ptr_next = next_index(held_ch);
        end else if (xfer && !lock) begin
            ptr_next = next_index(grant);
        end
`else
        if (xfer && !lock) ptr_next = next_index(grant);
`endif
    end

`ifdef RR_MUX_HOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            held_ch <= '0;
        end else begin
            state   <= state_next;
            held_ch <= held_ch_next;
        end
    end

    // Single-beat packets (last set while IDLE) never enter HELD.
    always_comb begin
        state_next   = state;
        held_ch_next = held_ch;
        case (state)
            IDLE: begin
                if (xfer && !in_last[grant]) begin
                    state_next   = HELD;
                    held_ch_next = grant;
                end
            end
            HELD: begin
                if (xfer && in_last[grant]) state_next = IDLE;
            end
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            ptr <= ptr_next;
            if (xfer) begin
                out_data  <= grant_data;
                out_sel   <= grant;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: scoreboard bench for rr_mux_n (4-channel instance plus a 3-channel instance).
// Hold-mode expectations are enabled when RR_MUX_HOLD_EN is defined.
module tb_rr_mux_n;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  in_last;
    logic        lock;
    logic [1:0]  lock_sel;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;

    int total;
    int bad;

    // Reference model of the 4-channel instance.
    int         m_ptr;
    logic       m_ov;
    logic       m_held;
    int         m_hch;
    logic [9:0] sb[$];

    rr_mux_n #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef RR_MUX_HOLD_EN
        .in_last(in_last),
`endif
        .lock(lock), .lock_sel(lock_sel), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_mux_n #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
`ifdef RR_MUX_HOLD_EN
        .in_last(3'b111),
`endif
        .lock(1'b0), .lock_sel(2'd0), .out_data(out_data3), .out_sel(out_sel3),
        .out_valid(out_valid3), .out_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_ov   = 1'b0;
        m_held = 1'b0;
        m_hch  = 0;
        sb.delete();
    endtask

    // One cycle: drive at negedge, check registered outputs and in_ready, then advance the model.
    task automatic applyStimulus(input logic [3:0] v, input logic lk, input logic [1:0] ls,
                                 input logic ordy, input logic [3:0] last);
        logic [3:0] elig;
        logic       found;
        logic       ld;
        logic [3:0] exp_rdy;
        logic [9:0] head;
        int         g;
        int         idx;
        @(negedge clk);
        in_valid  = v;
        lock      = lk;
        lock_sel  = ls;
        out_ready = ordy;
        in_last   = last;
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'($urandom);
        #1;
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        if (m_ov && sb.size() > 0) begin
            head = sb[0];
            checkOutput("out_sel", {30'b0, out_sel}, {30'b0, head[9:8]});
            checkOutput("out_data", {24'b0, out_data}, {24'b0, head[7:0]});
        end
        for (int i = 0; i < 4; i++) elig[i] = v[i] && (!lk || ls == 2'(i));
`ifdef RR_MUX_HOLD_EN
        if (m_held) for (int i = 0; i < 4; i++) elig[i] = v[i] && (i == m_hch);
`endif
        found = 1'b0;
        g     = 0;
        for (int off = 0; off < 4; off++) begin
            idx = (m_ptr + off) % 4;
            if (!found && elig[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        ld      = !m_ov || ordy;
        exp_rdy = (ld && found) ? 4'(1 << g) : 4'b0;
        checkOutput("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
        if (m_ov && ordy && sb.size() > 0) void'(sb.pop_front());
        if (ld && found) begin
            sb.push_back({2'(g), in_data[g*8 +: 8]});
            m_ov = 1'b1;
`ifdef RR_MUX_HOLD_EN
            if (m_held) begin
                if (last[g]) begin
                    m_held = 1'b0;
                    m_ptr  = (m_hch + 1) % 4;
                end
            end else begin
                if (!lk) m_ptr = (g + 1) % 4;
                if (!last[g]) begin
                    m_held = 1'b1;
                    m_hch  = g;
                end
            end
`else
            if (!lk) m_ptr = (g + 1) % 4;
`endif
        end else if (ordy) begin
            m_ov = 1'b0;
        end
    endtask

    // Async reset while a beat sits in the output register; the beat must vanish immediately.
    task automatic reset_mid_beat();
        @(posedge clk);
        #2;
        checkOutput("pre_rst_valid", {31'b0, out_valid}, {31'b0, m_ov});
        rst_n    = 1'b0;
        in_valid = 4'b0;
        #1;
        checkOutput("rst_async_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_async_ready", {28'b0, in_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_data   = 32'h44332211;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        lock      = 1'b0;
        lock_sel  = 2'd0;
        out_ready = 1'b1;
        in_data3  = 24'h323130;
        in_valid3 = 3'b111;
        model_reset();

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", {28'b0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {24'b0, out_data}, 32'd0);
        checkOutput("rst_out_sel", {30'b0, out_sel}, 32'd0);
        checkOutput("rst_in_ready3", {29'b0, in_ready3}, 32'd0);
        in_valid  = 4'b0;
        in_valid3 = 3'b0;
        rst_n     = 1'b1;

        $display("[TB] fairness");
        repeat (8) applyStimulus(4'hF, 1'b0, 2'd0, 1'b1, 4'hF);

        $display("[TB] backpressure");
        repeat (5) applyStimulus(4'hF, 1'b0, 2'd0, 1'b0, 4'hF);
        repeat (2) applyStimulus(4'hF, 1'b0, 2'd0, 1'b1, 4'hF);

        $display("[TB] forced mode");
        repeat (4) applyStimulus(4'hF, 1'b1, 2'd2, 1'b1, 4'hF);
        repeat (3) applyStimulus(4'b0111, 1'b1, 2'd3, 1'b1, 4'hF);
        repeat (3) applyStimulus(4'hF, 1'b0, 2'd3, 1'b1, 4'hF);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            applyStimulus(4'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
                          1'($urandom), 4'($urandom));
        end

        $display("[TB] mid-transfer reset");
        applyStimulus(4'hF, 1'b0, 2'd0, 1'b0, 4'hF);
        reset_mid_beat();

        $display("[TB] packet hold");
        applyStimulus(4'b0001, 1'b0, 2'd0, 1'b1, 4'hF);
        applyStimulus(4'b0011, 1'b0, 2'd0, 1'b1, 4'b1101);
        applyStimulus(4'b0011, 1'b0, 2'd0, 1'b1, 4'b1101);
        applyStimulus(4'b0011, 1'b0, 2'd0, 1'b1, 4'b1111);
        applyStimulus(4'b0011, 1'b0, 2'd0, 1'b1, 4'b1111);
        applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 4'b1111);
        applyStimulus(4'b0010, 1'b0, 2'd0, 1'b1, 4'b1101);
        applyStimulus(4'b0010, 1'b0, 2'd0, 1'b1, 4'b1101);
        reset_mid_beat();
        applyStimulus(4'b0011, 1'b0, 2'd0, 1'b1, 4'b1101);
        applyStimulus(4'b0011, 1'b0, 2'd0, 1'b1, 4'b1111);
        applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 4'b1111);

        $display("[TB] three channels");
        in_valid3 = 3'b101;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 4'hF);
            checkOutput("n3_valid", {31'b0, out_valid3}, 32'd1);
            checkOutput("n3_sel", {30'b0, out_sel3}, (k % 2 == 1) ? 32'd2 : 32'd0);
            checkOutput("n3_data", {24'b0, out_data3}, (k % 2 == 1) ? 32'h32 : 32'h30);
        end
        in_valid3 = 3'b0;
        applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 4'hF);
        applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 4'hF);
        checkOutput("n3_drained", {31'b0, out_valid3}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
